// File: rtl/cpu_clock_pkg.sv
// Shared types and default sizing for the BatPU CPU clock generator.
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } clk_state_t;

  localparam int unsigned DEF_CNT_W  = 32;
  localparam int unsigned DEF_DIV    = 599999;
  localparam int unsigned DEF_TICK_W = 16;

endpackage

// File: rtl/cpu_clock_gen_if.sv
// Control/status bundle between the CPU-side controller (master) and the clock generator (slave).
interface cpu_clock_gen_if
  import cpu_clock_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned TICK_W = DEF_TICK_W
) ();

  logic              run;
  logic              step_req;
  logic [CNT_W-1:0]  div_val;
  logic              tick;
  logic              clk_out;
  logic              busy;
  logic [TICK_W-1:0] tick_cnt;

  modport master (
    output run, step_req, div_val,
    input  tick, clk_out, busy, tick_cnt
  );

  modport slave (
    input  run, step_req, div_val,
    output tick, clk_out, busy, tick_cnt
  );

endinterface

// File: rtl/cpu_clock_sync.sv
// Two-flop synchronisers for run/step_req plus rising-edge detect on step_req.
// Latency: 2 clk for run, 2 clk for the step pulse; no backpressure.
module cpu_clock_sync (
  input  logic clk,
  input  logic rst,
  input  logic run_async,
  input  logic step_async,
  output logic run_sync,
  output logic step_pulse
);

  logic [1:0] run_ff;
  logic [1:0] step_ff;
  logic       step_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_ff    <= 2'b00;
      step_ff   <= 2'b00;
      step_prev <= 1'b0;
    end else begin
      run_ff    <= {run_ff[0], run_async};
      step_ff   <= {step_ff[0], step_async};
      step_prev <= step_ff[1];
    end
  end

  assign run_sync   = run_ff[1];
  assign step_pulse = step_ff[1] & ~step_prev;

endmodule

// File: rtl/cpu_clock_gen.sv
// CPU clock-enable generator with run/halt/single-step; tick is registered (1 clk after terminal count).
// No backpressure. Optional input synchronisers under CPU_CLOCK_INPUT_SYNC_EN.
module cpu_clock_gen
  import cpu_clock_pkg::*;
#(
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV),
  parameter int unsigned      TICK_W      = DEF_TICK_W,
  parameter bit               START_RUN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  cpu_clock_gen_if.slave  bus
);

  localparam clk_state_t RESET_STATE = START_RUN ? RUN : HALT;

  logic run_req;
  logic step_go;

`ifdef CPU_CLOCK_INPUT_SYNC_EN
  cpu_clock_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .run_async  (bus.run),
    .step_async (bus.step_req),
    .run_sync   (run_req),
    .step_pulse (step_go)
  );
`else
  assign run_req = bus.run;
  assign step_go = bus.step_req;
`endif

  clk_state_t        state;
  clk_state_t        state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  div_q;
  logic              terminal;
  logic              entering;
  logic              tick;
  logic              clk_out;
  logic              busy;
  logic [TICK_W-1:0] tick_cnt;

  // Compare before increment, so div_q = all-ones never needs count to overflow.
  assign terminal = (state != HALT) && (count == div_q);
  assign entering = (state == HALT) && (state_next != HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HALT: begin
        if (run_req)      state_next = RUN;
        else if (step_go) state_next = STEP;
      end
      RUN:     if (terminal && !run_req) state_next = HALT;
      STEP:    if (terminal)             state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    busy = (state != HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      div_q    <= DEFAULT_DIV;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick <= terminal;
      if (terminal) begin
        clk_out  <= ~clk_out;
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
      if (state == HALT || terminal) count <= '0;
      else                           count <= count + CNT_W'(1);
      // Period length only changes at a period boundary, never mid-period.
      if (terminal || entering) div_q <= bus.div_val;
    end
  end

  assign bus.tick     = tick;
  assign bus.clk_out  = clk_out;
  assign bus.busy     = busy;
  assign bus.tick_cnt = tick_cnt;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Directed bench for cpu_clock_gen: periods, div changes, halt/step control, tick_cnt wrap, mid-period reset.
module tb_cpu_clock_gen;

  logic clk = 1'b0;
  logic rst;
  logic rst4;

  always #5 clk = ~clk;

  cpu_clock_gen_if #(.CNT_W(32), .TICK_W(16)) bus ();
  cpu_clock_gen_if #(.CNT_W(32), .TICK_W(4))  bus4 ();

  cpu_clock_gen #(
    .CNT_W(32), .DEFAULT_DIV(32'd3), .TICK_W(16), .START_RUN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  cpu_clock_gen #(
    .CNT_W(32), .DEFAULT_DIV(32'd3), .TICK_W(4), .START_RUN(1'b0)
  ) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until the main DUT shows tick; -1 if none within the budget.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.tick !== 1'b1 && cyc < 200);
    if (bus.tick !== 1'b1) cyc = -1;
  endtask

  task automatic count_ticks(input int n, output int t);
    t = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.tick === 1'b1) t++;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t;
    int bad;
    logic exp_clk;

    rst = 1'b1;  bus.run = 1'b1;  bus.step_req = 1'b0;  bus.div_val = 32'd3;
    rst4 = 1'b1; bus4.run = 1'b0; bus4.step_req = 1'b0; bus4.div_val = 32'd1;
    step_clk(3);

    check_val("rst_tick",     bus.tick,      0);
    check_val("rst_clk_out",  bus.clk_out,   0);
    check_val("rst_busy",     bus.busy,      1);
    check_val("rst_tick_cnt", bus.tick_cnt,  0);
    check_val("rst4_busy",    bus4.busy,     0);

    // First tick on the 4th edge after release, then every 4 edges.
    rst = 1'b0;
    count_ticks(3, t);
    check_val("first_no_early_tick", t, 0);
    step_clk(1);
    check_val("first_tick", bus.tick, 1);
    check_val("first_clk_out", bus.clk_out, 1);
    bad = 0;
    for (int k = 2; k <= 20; k++) begin
      wait_tick(c);
      if (c != 4) bad++;
      if (bus.clk_out !== 1'(k % 2)) bad++;
    end
    check_val("div3_periods_clk_out", bad, 0);
    check_val("tick_cnt_20", bus.tick_cnt, 20);

    // div_val=0: takes effect at the next terminal, then a tick every cycle.
    bus.div_val = 32'd0;
    wait_tick(c);
    check_val("div0_reload_period", c, 4);
    exp_clk = bus.clk_out;
    for (int i = 0; i < 4; i++) begin
      step_clk(1);
      exp_clk = ~exp_clk;
      check_val("div0_tick", bus.tick, 1);
      check_val("div0_clk_out", bus.clk_out, exp_clk);
    end

    // 9 -> 2 change at count=4: current period still 10 cycles.
    bus.div_val = 32'd9;
    wait_tick(c);
    check_val("div9_load", c, 1);
    count_ticks(4, t);
    check_val("div9_mid_no_tick", t, 0);
    bus.div_val = 32'd2;
    wait_tick(c);
    check_val("div9_full_period", 4 + c, 10);
    wait_tick(c);
    check_val("div2_period_a", c, 3);
    wait_tick(c);
    check_val("div2_period_b", c, 3);

    // Halt request at count=2 of an 8-cycle period.
    bus.div_val = 32'd7;
    wait_tick(c);
    check_val("div7_load", c, 3);
    count_ticks(2, t);
    check_val("div7_mid_no_tick", t, 0);
    bus.run = 1'b0;
    wait_tick(c);
    check_val("halt_final_tick", 2 + c, 8);
    check_val("halt_busy", bus.busy, 0);
    count_ticks(100, t);
    check_val("halt_no_ticks", t, 0);
    check_val("halt_busy_held", bus.busy, 0);

    // Single step: one tick 6 edges after the request edge, then HALT.
    bus.div_val = 32'd4;
    bus.step_req = 1'b1;
    step_clk(1);
    bus.step_req = 1'b0;
    check_val("step_busy", bus.busy, 1);
    wait_tick(c);
    check_val("step_latency", 1 + c, 6);
    check_val("step_back_halt", bus.busy, 0);
    count_ticks(30, t);
    check_val("step_single_tick", t, 0);

    // run and step_req together: RUN wins and keeps ticking.
    bus.run = 1'b1;
    bus.step_req = 1'b1;
    step_clk(1);
    bus.step_req = 1'b0;
    check_val("both_busy", bus.busy, 1);
    count_ticks(20, t);
    check_val("both_run_ticks", t, 4);
    check_val("both_still_busy", bus.busy, 1);

    // TICK_W=4 instance: 17 ticks wrap tick_cnt to 1, then reset mid-period.
    rst4 = 1'b0;
    bus4.run = 1'b1;
    t = 0;
    c = 0;
    while (t < 17 && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      if (bus4.tick === 1'b1) t++;
    end
    check_val("w4_reached_17", t, 17);
    check_val("w4_tick_cnt_wrap", bus4.tick_cnt, 1);
    check_val("w4_clk_out", bus4.clk_out, 1);
    step_clk(1);
    rst4 = 1'b1;
    step_clk(1);
    check_val("w4_rst_tick",     bus4.tick,     0);
    check_val("w4_rst_clk_out",  bus4.clk_out,  0);
    check_val("w4_rst_busy",     bus4.busy,     0);
    check_val("w4_rst_tick_cnt", bus4.tick_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
